// File: rtl/traffic_phase_ctrl.sv
// Traffic-signal phase sequencer: per-phase programmable green/yellow timing with an
// all-red clearance between phases, plus hold, flashing-yellow and manual-step modes.
module traffic_phase_ctrl #(
    parameter int PHASES     = 4,
    parameter int TW         = 10,
    parameter int TICK_DIV   = 50000000,
    parameter int GREEN_DEF  = 30,
    parameter int YELLOW_DEF = 3,
    parameter int CLEAR_T    = 2,
    localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1,
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [1:0]        mode,
    input  logic              step,
    input  logic              cfg_we,
    input  logic [PW-1:0]     cfg_phase,
    input  logic [TW-1:0]     cfg_green,
    input  logic [TW-1:0]     cfg_yellow,
    output logic [PW-1:0]     phase,
    output logic [PHASES-1:0] grn,
    output logic [PHASES-1:0] yel,
    output logic [PHASES-1:0] red,
    output logic [TW-1:0]     remain_time,
    output logic              tick
);

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FLASH  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [CW-1:0]     tick_cnt_r;
    logic              first_r, first_s;
    logic              flash_r, flash_s;
    logic [TW-1:0]     grn_tab_r [PHASES];
    logic [TW-1:0]     yel_tab_r [PHASES];
    logic              cfg_wr_s;
    logic [PW-1:0]     next_phase_s, phase_s;
    logic [TW-1:0]     green_ld_s, yellow_ld_s, remain_s;
    logic [PHASES-1:0] grn_s, yel_s, red_s;

    function automatic logic [TW-1:0] at_least_one(input logic [TW-1:0] d);
        return (d == '0) ? TW'(1) : d;
    endfunction

    assign cfg_wr_s = cfg_we && (32'(cfg_phase) < PHASES);

    // One-second tick: free-running divider, pulse registered after the terminal count
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt_r <= '0;
            tick       <= 1'b0;
        end else begin
            tick <= (tick_cnt_r == CW'(TICK_DIV - 1));
            if (tick_cnt_r == CW'(TICK_DIV - 1)) tick_cnt_r <= '0;
            else                                 tick_cnt_r <= tick_cnt_r + CW'(1);
        end
    end

    // Duration table; out-of-range phase writes are dropped
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < PHASES; i++) begin
                grn_tab_r[i] <= TW'(GREEN_DEF);
                yel_tab_r[i] <= TW'(YELLOW_DEF);
            end
        end else if (cfg_wr_s) begin
            grn_tab_r[cfg_phase] <= cfg_green;
            yel_tab_r[cfg_phase] <= cfg_yellow;
        end
    end

    // Interval lengths to load; a same-cycle write to the loaded phase is forwarded
    always_comb begin
        next_phase_s = '0;
        green_ld_s   = '0;
        yellow_ld_s  = '0;
        if (first_r || phase == PW'(PHASES - 1)) next_phase_s = '0;
        else                                     next_phase_s = phase + PW'(1);
        if (cfg_wr_s && cfg_phase == next_phase_s) green_ld_s = at_least_one(cfg_green);
        else                                       green_ld_s = at_least_one(grn_tab_r[next_phase_s]);
        if (cfg_wr_s && cfg_phase == phase) yellow_ld_s = at_least_one(cfg_yellow);
        else                                yellow_ld_s = at_least_one(yel_tab_r[phase]);
    end

    // Next state: mode overrides first, then manual step, then tick-driven countdown
    always_comb begin
        state_s  = state_r;
        phase_s  = phase;
        remain_s = remain_time;
        first_s  = first_r;
        flash_s  = flash_r;
        case (mode)
            2'd1: begin
                state_s  = ST_HOLD;
                remain_s = '0;
                first_s  = 1'b0;
            end
            2'd2: begin
                if (state_r != ST_FLASH) begin
                    state_s  = ST_FLASH;
                    remain_s = '0;
                    flash_s  = 1'b0;
                    first_s  = 1'b0;
                end else if (tick) begin
                    flash_s = ~flash_r;
                end else begin
                    flash_s = flash_r;
                end
            end
            default: begin
                if (state_r == ST_HOLD || state_r == ST_FLASH) begin
                    state_s  = ST_CLEAR;
                    remain_s = TW'(CLEAR_T);
                end else if (mode == 2'd3 && state_r == ST_GREEN) begin
                    // manual hold: green is frozen until a step releases it
                    if (step) begin
                        state_s  = ST_YELLOW;
                        remain_s = yellow_ld_s;
                    end else begin
                        state_s = state_r;
                    end
                end else if (tick) begin
                    if (remain_time > TW'(1)) begin
                        remain_s = remain_time - TW'(1);
                    end else begin
                        case (state_r)
                            ST_CLEAR: begin
                                state_s  = ST_GREEN;
                                phase_s  = next_phase_s;
                                remain_s = green_ld_s;
                                first_s  = 1'b0;
                            end
                            ST_GREEN: begin
                                state_s  = ST_YELLOW;
                                remain_s = yellow_ld_s;
                            end
                            default: begin
                                state_s  = ST_CLEAR;
                                remain_s = TW'(CLEAR_T);
                            end
                        endcase
                    end
                end else begin
                    state_s = state_r;
                end
            end
        endcase
    end

    // Lamp vectors derived from the next state so they register alongside it
    always_comb begin
        grn_s = '0;
        yel_s = '0;
        red_s = '1;
        case (state_s)
            ST_GREEN: begin
                grn_s[phase_s] = 1'b1;
                red_s[phase_s] = 1'b0;
            end
            ST_YELLOW: begin
                yel_s[phase_s] = 1'b1;
                red_s[phase_s] = 1'b0;
            end
            ST_FLASH: begin
                red_s = '0;
                yel_s = flash_s ? '1 : '0;
            end
            default: begin
                red_s = '1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= ST_CLEAR;
            phase       <= '0;
            remain_time <= TW'(CLEAR_T);
            first_r     <= 1'b1;
            flash_r     <= 1'b0;
            grn         <= '0;
            yel         <= '0;
            red         <= '1;
        end else begin
            state_r     <= state_s;
            phase       <= phase_s;
            remain_time <= remain_s;
            first_r     <= first_s;
            flash_r     <= flash_s;
            grn         <= grn_s;
            yel         <= yel_s;
            red         <= red_s;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus random traffic, every cycle
// compared against an interval-level model of the signal sequence.
module tb_traffic_phase_ctrl;

    localparam int PHASES = 4, TW = 10, TICK_DIV = 4;
    localparam int GREEN_DEF = 30, YELLOW_DEF = 3, CLEAR_T = 2;
    localparam int K_CLEAR = 0, K_GREEN = 1, K_YELLOW = 2, K_HOLD = 3, K_FLASH = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic [1:0]        mode = 2'd0;
    logic              step = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_phase = 2'd0;
    logic [TW-1:0]     cfg_green = '0;
    logic [TW-1:0]     cfg_yellow = '0;
    logic [1:0]        phase;
    logic [PHASES-1:0] grn, yel, red;
    logic [TW-1:0]     remain_time;
    logic              tick;

    int tests = 0;
    int fails = 0;

    // model: the current interval (kind, phase, seconds left) plus the duration table
    int m_k, m_kind, m_phase, m_left;
    bit m_first, m_flash;
    int m_g[PHASES];
    int m_y[PHASES];

    traffic_phase_ctrl #(
        .PHASES(PHASES), .TW(TW), .TICK_DIV(TICK_DIV),
        .GREEN_DEF(GREEN_DEF), .YELLOW_DEF(YELLOW_DEF), .CLEAR_T(CLEAR_T)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .step(step),
        .cfg_we(cfg_we), .cfg_phase(cfg_phase), .cfg_green(cfg_green),
        .cfg_yellow(cfg_yellow), .phase(phase), .grn(grn), .yel(yel), .red(red),
        .remain_time(remain_time), .tick(tick)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int dur(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_k = 0; m_kind = K_CLEAR; m_phase = 0; m_left = CLEAR_T;
        m_first = 1'b1; m_flash = 1'b0;
        for (int i = 0; i < PHASES; i++) begin
            m_g[i] = GREEN_DEF;
            m_y[i] = YELLOW_DEF;
        end
    endtask

    // one clock edge of the signal plan, from the inputs presented at that edge
    task automatic model_step();
        bit tk;
        tk = (m_k > 0) && (m_k % TICK_DIV == 0);
        m_k++;
        if (cfg_we) begin
            m_g[cfg_phase] = int'(cfg_green);
            m_y[cfg_phase] = int'(cfg_yellow);
        end
        if (mode == 2'd1) begin
            m_kind = K_HOLD; m_left = 0; m_first = 1'b0;
        end else if (mode == 2'd2) begin
            if (m_kind != K_FLASH) begin
                m_kind = K_FLASH; m_left = 0; m_flash = 1'b0; m_first = 1'b0;
            end else if (tk) begin
                m_flash = !m_flash;
            end
        end else if (m_kind == K_HOLD || m_kind == K_FLASH) begin
            m_kind = K_CLEAR; m_left = CLEAR_T;
        end else if (mode == 2'd3 && m_kind == K_GREEN) begin
            if (step) begin
                m_kind = K_YELLOW; m_left = dur(m_y[m_phase]);
            end
        end else if (tk) begin
            if (m_left > 1) m_left--;
            else if (m_kind == K_CLEAR) begin
                m_phase = m_first ? 0 : (m_phase + 1) % PHASES;
                m_first = 1'b0;
                m_kind = K_GREEN; m_left = dur(m_g[m_phase]);
            end else if (m_kind == K_GREEN) begin
                m_kind = K_YELLOW; m_left = dur(m_y[m_phase]);
            end else begin
                m_kind = K_CLEAR; m_left = CLEAR_T;
            end
        end
    endtask

    task automatic check_all();
        logic [PHASES-1:0] one, eg, ey, er;
        one = PHASES'(1) << m_phase;
        eg = '0; ey = '0; er = '1;
        if (m_kind == K_GREEN) begin
            eg = one; er = ~one;
        end else if (m_kind == K_YELLOW) begin
            ey = one; er = ~one;
        end else if (m_kind == K_FLASH) begin
            er = '0; ey = m_flash ? '1 : '0;
        end
        chk("phase", int'(phase), m_phase);
        chk("grn", int'(grn), int'(eg));
        chk("yel", int'(yel), int'(ey));
        chk("red", int'(red), int'(er));
        chk("remain_time", int'(remain_time), m_left);
        chk("tick", int'(tick), int'((m_k > 0) && (m_k % TICK_DIV == 0)));
    endtask

    task automatic run_cycle();
        @(posedge sys_clk);
        if (!sys_rst) model_step();
        @(negedge sys_clk);
        check_all();
        step = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic wait_model(input string nm, input int kd, input int ph, input int lf, input int budget);
        int n;
        n = 0;
        while (!(m_kind == kd && (ph < 0 || m_phase == ph) && (lf < 0 || m_left == lf)) && n < budget) begin
            run_cycle();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL wait_%s: not reached in %0d cycles, at kind %0d phase %0d left %0d", nm, budget, m_kind, m_phase, m_left);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_phase"}, int'(phase), 0);
        chk({nm, "_grn"}, int'(grn), 0);
        chk({nm, "_yel"}, int'(yel), 0);
        chk({nm, "_red"}, int'(red), 15);
        chk({nm, "_remain"}, int'(remain_time), 2);
        chk({nm, "_tick"}, int'(tick), 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_reset_vals("por");
        check_all();
        #2 sys_rst = 1'b0;

        // first CLEAR counts 2,1 then green phase 0 loads 30
        for (int i = 1; i <= 9; i++) begin
            run_cycle();
            if (i == 4) chk("first_tick", int'(tick), 1);
            if (i == 8) chk("clear_last", int'(remain_time), 1);
        end
        chk("green0_load", int'(remain_time), 30);
        chk("green0_lamp", int'(grn), 1);

        // reprogram phase 2 while phase 0 is green
        repeat (20) run_cycle();
        cfg_we = 1'b1; cfg_phase = 2'd2; cfg_green = TW'(5); cfg_yellow = TW'(0);
        run_cycle();
        wait_model("y0", K_YELLOW, 0, 3, 200);
        chk("yellow0_load", int'(remain_time), 3);
        chk("yellow0_lamp", int'(yel), 1);
        wait_model("g2", K_GREEN, 2, 5, 400);
        chk("green2_prog", int'(remain_time), 5);
        chk("green2_lamp", int'(grn), 4);
        wait_model("y2", K_YELLOW, 2, 1, 40);
        chk("yellow2_zero", int'(remain_time), 1);

        // flashing yellow from phase 1 yellow, then back to normal
        wait_model("y1", K_YELLOW, 1, 2, 800);
        mode = 2'd2;
        run_cycle();
        chk("flash_red", int'(red), 0);
        chk("flash_grn", int'(grn), 0);
        chk("flash_yel", int'(yel), 0);
        chk("flash_remain", int'(remain_time), 0);
        repeat (12) run_cycle();
        mode = 2'd0;
        run_cycle();
        chk("unflash_remain", int'(remain_time), 2);
        chk("unflash_red", int'(red), 15);
        wait_model("g2b", K_GREEN, 2, 5, 40);
        chk("unflash_grn", int'(grn), 4);

        // all-red hold mid green of phase 3, release wraps to phase 0
        wait_model("g3", K_GREEN, 3, 15, 400);
        mode = 2'd1;
        run_cycle();
        chk("hold_red", int'(red), 15);
        chk("hold_remain", int'(remain_time), 0);
        repeat (10) run_cycle();
        chk("hold_phase", int'(phase), 3);
        mode = 2'd0;
        wait_model("g0", K_GREEN, 0, 30, 40);
        chk("wrap_grn", int'(grn), 1);

        // manual mode: freeze, step through, step during yellow ignored
        wait_model("g0_17", K_GREEN, 0, 17, 200);
        mode = 2'd3;
        repeat (40) run_cycle();
        chk("manual_frozen", int'(remain_time), 17);
        step = 1'b1;
        run_cycle();
        chk("step_yel", int'(yel), 1);
        chk("step_remain", int'(remain_time), 3);
        repeat (2) run_cycle();
        step = 1'b1;
        run_cycle();
        chk("step_in_yellow", int'(yel), 1);
        wait_model("g1", K_GREEN, 1, 30, 100);
        repeat (20) run_cycle();
        chk("manual_held", int'(remain_time), 30);
        chk("manual_grn", int'(grn), 2);
        mode = 2'd0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
            step = ($urandom_range(0, 19) == 0);
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_phase = 2'($urandom_range(0, 3));
            cfg_green = TW'($urandom_range(0, 6));
            cfg_yellow = TW'($urandom_range(0, 3));
            run_cycle();
        end

        // asynchronous reset mid-yellow restores outputs and table
        mode = 2'd0;
        wait_model("y_any", K_YELLOW, -1, -1, 800);
        #2 sys_rst = 1'b1;
        #1 chk_reset_vals("arst");
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_all();
        #2 sys_rst = 1'b0;
        wait_model("rg0", K_GREEN, 0, 30, 100);
        chk("rst_table_green", int'(remain_time), 30);
        wait_model("ry0", K_YELLOW, 0, -1, 200);
        chk("rst_table_yellow", int'(remain_time), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
